tp_b_row_streamer: RTL and testbench

//  Downstream consumer of the transpose stage. After the transpose completes, it reads
//   the transposed matrix B from the B-buffer CPU-style read port, one FP32 word at a time.
//  It assembles each B row into one packed beat and emits it on a valid/ready stream
//   to the systolic-array operand feeder.
//  B has NCols rows x NRows cols, where B[i][j] = A[j][i].

---
 rtl/tp_b_row_streamer.sv | 162 ++++++++++++++++
 tb/tb_tp_b_row_streamer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_b_row_streamer.sv
// Reads transposed matrix B word by word from the B-buffer read port and emits
// each assembled B row as one packed beat on a valid/ready stream.
module tp_b_row_streamer #(
  parameter int unsigned NRows  = 8,
  parameter int unsigned NCols  = 8,
  parameter int unsigned Data_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    b_re,
  output logic [31:0]             b_row,
  output logic [31:0]             b_col,
  input  logic [Data_W-1:0]       b_rdata,
  input  logic                    b_rvalid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NRows*Data_W-1:0] out_data,
  output logic [31:0]             out_row,
  output logic                    out_last
);

  localparam int unsigned CntW  = 32;
  localparam int unsigned LaneW = (NRows > 1) ? $clog2(NRows) : 1;
  localparam logic [CntW-1:0] ColMax = CntW'(NRows - 1);
  localparam logic [CntW-1:0] RowMax = CntW'(NCols - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                        state, state_n;
  logic [CntW-1:0]               row_cnt, row_n;
  logic [CntW-1:0]               col_cnt, col_n;
  logic                          busy_n, done_n, b_re_n, out_valid_n, out_last_n;
  logic [CntW-1:0]               b_row_n, b_col_n, out_row_n;
  logic                          lane_we;
  logic [NRows-1:0][Data_W-1:0]  row_buf;
  logic [LaneW-1:0]              lane;

  assign lane     = col_cnt[LaneW-1:0];
  assign out_data = row_buf;

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      col_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      b_re      <= 1'b0;
      b_row     <= '0;
      b_col     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      row_cnt   <= row_n;
      col_cnt   <= col_n;
      busy      <= busy_n;
      done      <= done_n;
      b_re      <= b_re_n;
      b_row     <= b_row_n;
      b_col     <= b_col_n;
      out_valid <= out_valid_n;
      out_row   <= out_row_n;
      out_last  <= out_last_n;
    end
  end

  // Row assembly register; it doubles as the held output beat while in OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf <= '0;
    end else if (lane_we) begin
      row_buf[lane] <= b_rdata;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_n     = state;
    row_n       = row_cnt;
    col_n       = col_cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    b_re_n      = 1'b0;
    b_row_n     = b_row;
    b_col_n     = b_col;
    out_valid_n = 1'b0;
    out_row_n   = out_row;
    out_last_n  = out_last;
    lane_we     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          row_n   = '0;
          col_n   = '0;
          busy_n  = 1'b1;
          b_re_n  = 1'b1;
          b_row_n = '0;
          b_col_n = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (b_rvalid) begin
          lane_we = 1'b1;
          if (col_cnt < ColMax) begin
            col_n   = col_cnt + CntW'(1);
            b_re_n  = 1'b1;
            b_row_n = row_cnt;
            b_col_n = col_cnt + CntW'(1);
            state_n = S_ISSUE;
          end else begin
            out_valid_n = 1'b1;
            out_row_n   = row_cnt;
            out_last_n  = (row_cnt == RowMax);
            state_n     = S_OUT;
          end
        end
      end
      S_OUT: begin
        out_valid_n = 1'b1;
        if (out_ready) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          if (row_cnt < RowMax) begin
            row_n   = row_cnt + CntW'(1);
            col_n   = '0;
            b_re_n  = 1'b1;
            b_row_n = row_cnt + CntW'(1);
            b_col_n = '0;
            state_n = S_ISSUE;
          end else begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tp_b_row_streamer.sv
// Directed bench for tp_b_row_streamer: B-buffer model with selectable read
// latency, beat/request monitor, one task per scenario.
module tb_tp_b_row_streamer;

  localparam int unsigned NROWS = 8;
  localparam int unsigned NCOLS = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = NROWS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, b_re, out_valid, out_last;
  logic [31:0]   b_row, b_col, out_row;
  logic [DW-1:0] b_rdata = '0;
  logic          b_rvalid = 1'b0;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit spur = 1'b0;

  logic [BW-1:0] bq_data[$];
  logic [31:0]   bq_row[$];
  logic          bq_last[$];
  int            bq_cyc[$];
  logic [31:0]   rq_row[$];
  logic [31:0]   rq_col[$];
  int            rq_cyc[$];
  int            ndone = 0;
  int            done_cyc = 0;

  bit            m_pend = 1'b0;
  int            m_cnt = 0;
  logic [31:0]   m_row = '0;
  logic [31:0]   m_col = '0;

  tp_b_row_streamer #(.NRows(NROWS), .NCols(NCOLS), .Data_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .b_re(b_re), .b_row(b_row), .b_col(b_col), .b_rdata(b_rdata),
    .b_rvalid(b_rvalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bval(input logic [31:0] r, input logic [31:0] c);
    return 32'h3f80_0000 + {c[23:0], 8'h00} + r;
  endfunction

  function automatic logic [BW-1:0] exp_beat(input int i);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < NROWS; j++) v[j*DW +: DW] = 32'h3f80_0000 + 32'(j) * 32'd256 + 32'(i);
    return v;
  endfunction

  // B-buffer model: response appears lat cycles after the request cycle
  always @(posedge clk) begin
    if (m_pend) begin
      if (m_cnt <= 1) begin
        b_rvalid <= 1'b1;
        b_rdata  <= bval(m_row, m_col);
        m_pend   <= 1'b0;
      end else begin
        m_cnt    <= m_cnt - 1;
        b_rvalid <= 1'b0;
      end
    end else if (spur) begin
      b_rvalid <= 1'b1;
      b_rdata  <= 32'hDEAD_BEEF;
    end else begin
      b_rvalid <= 1'b0;
    end
    if (b_re) begin
      if (lat == 1) begin
        b_rvalid <= 1'b1;
        b_rdata  <= bval(b_row, b_col);
      end else begin
        m_pend <= 1'b1;
        m_cnt  <= lat - 1;
        m_row  <= b_row;
        m_col  <= b_col;
      end
    end
  end

  // Monitor: handshaken beats, read requests and done pulses
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      bq_data.push_back(out_data);
      bq_row.push_back(out_row);
      bq_last.push_back(out_last);
      bq_cyc.push_back(cyc);
    end
    if (b_re) begin
      rq_row.push_back(b_row);
      rq_col.push_back(b_col);
      rq_cyc.push_back(cyc);
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      #1;
      if (ndone > d0) ok = 1'b1;
    end
  endtask

  task automatic wait_beat(input int row, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      if (out_valid && out_row == 32'(row)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, b_re, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/b_re/out_valid/out_last=%b, required 00000",
               {busy, done, b_re, out_valid, out_last});
    end
    checks++;
    if ({b_row, b_col, out_row} !== 96'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: b_row=%0d b_col=%0d out_row=%0d out_data=%h, required all 0",
               b_row, b_col, out_row, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, b_re, out_valid} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: busy/b_re/out_valid=%b, required 000", {busy, b_re, out_valid});
    end
  endtask

  task automatic test_basic();
    int s, b0, r0, d0;
    bit ok;
    b0 = bq_data.size(); r0 = rq_row.size(); d0 = ndone;
    pulse_start(s);
    wait_done(d0, 400, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: no done within 400 cycles"); end
    checks++;
    if (bq_data.size() - b0 != NCOLS) begin
      errors++; $display("FAIL basic_beats: got %0d beats, required %0d", bq_data.size() - b0, NCOLS);
    end
    if (bq_data.size() >= b0 + NCOLS) begin
      for (int i = 0; i < NCOLS; i++) begin
        checks++;
        if (bq_data[b0+i] !== exp_beat(i) || bq_row[b0+i] !== 32'(i) || bq_last[b0+i] !== (i == NCOLS - 1)) begin
          errors++;
          $display("FAIL basic_beat%0d: row=%0d last=%b data=%h, required row=%0d last=%b data=%h",
                   i, bq_row[b0+i], bq_last[b0+i], bq_data[b0+i], i, (i == NCOLS - 1), exp_beat(i));
        end
      end
      checks++;
      if (bq_cyc[b0] - s != 2 * NROWS + 1) begin
        errors++; $display("FAIL basic_beat0_cycle: %0d, required %0d", bq_cyc[b0] - s, 2 * NROWS + 1);
      end
    end
    checks++;
    if (ndone - d0 != 1) begin errors++; $display("FAIL basic_done_count: %0d, required 1", ndone - d0); end
    // Cycle index counts the start-sampling cycle as cycle 1
    checks++;
    if (done_cyc - s + 1 != 138) begin
      errors++; $display("FAIL basic_done_cycle: %0d, required 138", done_cyc - s + 1);
    end
    checks++;
    if (rq_row.size() - r0 != NROWS * NCOLS || rq_cyc[r0] - s != 1) begin
      errors++;
      $display("FAIL basic_reads: count=%0d first_at=%0d, required count=64 first_at=1",
               rq_row.size() - r0, rq_cyc[r0] - s);
    end
    checks++;
    if ({busy, done, out_valid} !== 3'b0) begin
      errors++; $display("FAIL basic_idle_after: busy/done/out_valid=%b, required 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_stall();
    int s, b0, d0;
    bit ok, stable, re_seen;
    b0 = bq_data.size(); d0 = ndone;
    out_ready = 1'b1;
    pulse_start(s);
    wait_beat(1, 200, ok);
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (ok) wait_beat(2, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: beat 2 never valid"); end
    stable = 1'b1; re_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!out_valid || out_data !== exp_beat(2) || out_row !== 32'd2) stable = 1'b0;
      if (b_re) re_seen = 1'b1;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL stall_hold: valid=%b row=%0d data=%h, required valid=1 row=2 data=%h",
                         out_valid, out_row, out_data, exp_beat(2));
    end
    checks++;
    if (re_seen) begin errors++; $display("FAIL stall_no_read: b_re=1 seen, required 0"); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(d0, 400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != NCOLS || ndone - d0 != 1) begin
      errors++; $display("FAIL stall_run: beats=%0d dones=%0d, required 8 and 1", bq_data.size() - b0, ndone - d0);
    end
    if (bq_data.size() >= b0 + NCOLS) begin
      for (int i = 3; i < NCOLS; i++) begin
        checks++;
        if (bq_data[b0+i] !== exp_beat(i) || bq_row[b0+i] !== 32'(i)) begin
          errors++; $display("FAIL stall_beat%0d: row=%0d data=%h, required row=%0d data=%h",
                             i, bq_row[b0+i], bq_data[b0+i], i, exp_beat(i));
        end
      end
    end
  endtask

  task automatic test_latency3();
    int s, b0, r0, d0, bad_addr, min_gap;
    bit ok, beats_ok;
    lat = 3;
    b0 = bq_data.size(); r0 = rq_row.size(); d0 = ndone;
    pulse_start(s);
    wait_done(d0, 1000, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != NCOLS) begin
      errors++; $display("FAIL lat3_run: done=%b beats=%0d, required done and 8 beats", ok, bq_data.size() - b0);
    end
    beats_ok = (bq_data.size() >= b0 + NCOLS);
    for (int i = 0; i < NCOLS && beats_ok; i++)
      if (bq_data[b0+i] !== exp_beat(i) || bq_row[b0+i] !== 32'(i)) beats_ok = 1'b0;
    checks++;
    if (!beats_ok) begin errors++; $display("FAIL lat3_beats: beat contents differ from B rows"); end
    checks++;
    if (rq_row.size() - r0 != NROWS * NCOLS) begin
      errors++; $display("FAIL lat3_read_count: %0d, required 64", rq_row.size() - r0);
    end
    bad_addr = 0; min_gap = 1000;
    for (int k = 0; k < NROWS * NCOLS && r0 + k < rq_row.size(); k++) begin
      if (rq_row[r0+k] !== 32'(k / NROWS) || rq_col[r0+k] !== 32'(k % NROWS)) bad_addr++;
      if (k > 0 && rq_cyc[r0+k] - rq_cyc[r0+k-1] < min_gap) min_gap = rq_cyc[r0+k] - rq_cyc[r0+k-1];
    end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL lat3_addr_order: %0d out-of-order addresses, required 0", bad_addr); end
    checks++;
    if (min_gap < 4) begin errors++; $display("FAIL lat3_one_outstanding: min request gap %0d, required >=4", min_gap); end
    lat = 1;
  endtask

  task automatic test_start_ignored();
    int s, b0, d0;
    bit ok;
    b0 = bq_data.size(); d0 = ndone;
    pulse_start(s);
    wait_beat(4, 200, ok);
    pulse_start(s);
    wait_done(d0, 400, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != NCOLS || ndone - d0 != 1) begin
      errors++; $display("FAIL start_busy_ignored: beats=%0d dones=%0d, required 8 and 1", bq_data.size() - b0, ndone - d0);
    end
    wait_done(d0 + 1, 4, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL start_busy_rerun: extra done seen, required none"); end
    // Restart two cycles after a done pulse
    b0 = bq_data.size(); d0 = ndone;
    pulse_start(s);
    wait_done(d0, 400, ok);
    @(posedge clk);
    pulse_start(s);
    wait_done(d0 + 1, 400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != 2 * NCOLS || ndone - d0 != 2) begin
      errors++; $display("FAIL restart_run: beats=%0d dones=%0d, required 16 and 2", bq_data.size() - b0, ndone - d0);
    end
    if (bq_data.size() >= b0 + 2 * NCOLS) begin
      for (int i = 0; i < NCOLS; i++) begin
        checks++;
        if (bq_data[b0+NCOLS+i] !== exp_beat(i) || bq_row[b0+NCOLS+i] !== 32'(i)) begin
          errors++; $display("FAIL restart_beat%0d: row=%0d, required row=%0d with matching data",
                             i, bq_row[b0+NCOLS+i], i);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int s, b0, d0;
    bit ok;
    b0 = bq_data.size(); d0 = ndone;
    pulse_start(s);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bq_data.size() == b0 + 3 && busy && !b_re && !out_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_timeout: never reached WAIT of beat 3"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, b_re, out_valid, out_last} !== 5'b0 || {b_row, b_col, out_row} !== 96'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl=%b b_row=%0d b_col=%0d out_row=%0d data=%h, required all 0",
               {busy, done, b_re, out_valid, out_last}, b_row, b_col, out_row, out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (ndone != d0 || bq_data.size() != b0 + 3 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_aborted: dones=%0d beats=%0d busy=%b, required 0 3 0",
                         ndone - d0, bq_data.size() - b0, busy);
    end
    b0 = bq_data.size();
    pulse_start(s);
    wait_done(d0, 400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != NCOLS || ndone - d0 != 1) begin
      errors++; $display("FAIL rst_mid_rerun: beats=%0d dones=%0d, required 8 and 1", bq_data.size() - b0, ndone - d0);
    end
    if (bq_data.size() >= b0 + NCOLS) begin
      checks++;
      if (bq_data[b0] !== exp_beat(0) || bq_data[b0+7] !== exp_beat(7) || bq_last[b0+7] !== 1'b1) begin
        errors++; $display("FAIL rst_mid_rerun_data: beat0=%h, required %h", bq_data[b0], exp_beat(0));
      end
    end
  endtask

  task automatic test_spurious();
    int s, b0, r0, d0;
    bit ok;
    r0 = rq_row.size();
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_data !== exp_beat(7) || {busy, b_re, out_valid} !== 3'b0 || rq_row.size() != r0) begin
      errors++; $display("FAIL spur_idle: data=%h ctrl=%b, required data=%h ctrl=000",
                         out_data, {busy, b_re, out_valid}, exp_beat(7));
    end
    b0 = bq_data.size(); d0 = ndone;
    out_ready = 1'b1;
    pulse_start(s);
    wait_beat(4, 200, ok);
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (ok) wait_beat(5, 200, ok);
    r0 = rq_row.size();
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || out_data !== exp_beat(5) || out_valid !== 1'b1 || out_row !== 32'd5 || rq_row.size() != r0) begin
      errors++; $display("FAIL spur_out: valid=%b row=%0d data=%h, required valid=1 row=5 data=%h",
                         out_valid, out_row, out_data, exp_beat(5));
    end
    out_ready = 1'b1;
    wait_done(d0, 400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || bq_data.size() - b0 != NCOLS || ndone - d0 != 1) begin
      errors++; $display("FAIL spur_run: beats=%0d dones=%0d, required 8 and 1", bq_data.size() - b0, ndone - d0);
    end
    if (bq_data.size() >= b0 + NCOLS) begin
      checks++;
      if (bq_data[b0+5] !== exp_beat(5) || bq_data[b0+6] !== exp_beat(6)) begin
        errors++; $display("FAIL spur_beats: beat5=%h, required %h", bq_data[b0+5], exp_beat(5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latency3();
    test_start_ignored();
    test_reset_midrun();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
